mem_wb_pipeline_reg: RTL and testbench

MEM/WB pipeline register for the datapath pipeline. Each cycle the pipeline advances, it captures the top and bottom result bytes produced by `mem_wb_data_input_mux`, along with the write-back register addresses and write enables for the current instruction. It also keeps a one-deep history copy (t-1) of the previous contents. The `mem_wb_*` and `mem_wb_tm1_*` outputs feed back into `mem_wb_data_input_mux` for forwarding and go forward to the register-file write port; the block also supports stall, flush/bubble insertion and a retirement counter.

---
 rtl/mem_wb_pipeline_reg.sv | 102 ++++++++++
 tb/tb_mem_wb_pipeline_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipeline_reg.sv
// MEM/WB pipeline register: captures the result byte lanes, destination addresses and
// write enables, and keeps a one-deep history copy plus a retired-instruction counter.
module mem_wb_pipeline_reg #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     data_top_in,
  input  logic [DATA_W-1:0]     data_bot_in,
  input  logic [REG_ADDR_W-1:0] rd_top_in,
  input  logic [REG_ADDR_W-1:0] rd_bot_in,
  input  logic                  we_top_in,
  input  logic                  we_bot_in,
  input  logic                  valid_in,
  output logic [DATA_W-1:0]     mem_wb_top,
  output logic [DATA_W-1:0]     mem_wb_bot,
  output logic [DATA_W-1:0]     mem_wb_tm1_top,
  output logic [DATA_W-1:0]     mem_wb_tm1_bot,
  output logic [REG_ADDR_W-1:0] rd_top,
  output logic [REG_ADDR_W-1:0] rd_bot,
  output logic                  we_top,
  output logic                  we_bot,
  output logic                  valid,
  output logic                  tm1_valid,
  output logic                  wr_collision,
  output logic [CNT_W-1:0]      retire_count
);

  logic [DATA_W-1:0]     r_top, r_bot, r_tm1Top, r_tm1Bot;
  logic [REG_ADDR_W-1:0] r_rdTop, r_rdBot;
  logic                  r_weTop, r_weBot, r_valid, r_tm1Valid, r_collision;
  logic [CNT_W-1:0]      r_retireCount;

  logic w_advance;
  logic w_dup;

  // A flush forces the stage to move even while stalled so the bubble is inserted.
  assign w_advance = ~stall | flush;
  assign w_dup     = we_top_in & we_bot_in & (rd_top_in == rd_bot_in);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_top         <= '0;
      r_bot         <= '0;
      r_tm1Top      <= '0;
      r_tm1Bot      <= '0;
      r_rdTop       <= '0;
      r_rdBot       <= '0;
      r_weTop       <= 1'b0;
      r_weBot       <= 1'b0;
      r_valid       <= 1'b0;
      r_tm1Valid    <= 1'b0;
      r_collision   <= 1'b0;
      r_retireCount <= '0;
    end else if (w_advance) begin
      r_tm1Top   <= r_top;
      r_tm1Bot   <= r_bot;
      r_tm1Valid <= r_valid;
      if (r_valid) begin
        r_retireCount <= r_retireCount + CNT_W'(1);
      end
      if (flush) begin
        r_top       <= '0;
        r_bot       <= '0;
        r_rdTop     <= '0;
        r_rdBot     <= '0;
        r_weTop     <= 1'b0;
        r_weBot     <= 1'b0;
        r_valid     <= 1'b0;
        r_collision <= 1'b0;
      end else begin
        // Top lane wins a same-address dual write; the bottom enable is suppressed.
        r_top       <= data_top_in;
        r_bot       <= data_bot_in;
        r_rdTop     <= rd_top_in;
        r_rdBot     <= rd_bot_in;
        r_weTop     <= we_top_in & valid_in;
        r_weBot     <= we_bot_in & valid_in & ~w_dup;
        r_valid     <= valid_in;
        r_collision <= w_dup & valid_in;
      end
    end
  end

  assign mem_wb_top     = r_top;
  assign mem_wb_bot     = r_bot;
  assign mem_wb_tm1_top = r_tm1Top;
  assign mem_wb_tm1_bot = r_tm1Bot;
  assign rd_top         = r_rdTop;
  assign rd_bot         = r_rdBot;
  assign we_top         = r_weTop;
  assign we_bot         = r_weBot;
  assign valid          = r_valid;
  assign tm1_valid      = r_tm1Valid;
  assign wr_collision   = r_collision;
  assign retire_count   = r_retireCount;

endmodule

// File: tb/tb_mem_wb_pipeline_reg.sv
// Self-checking bench for mem_wb_pipeline_reg: directed vector table, reset corners,
// randomized traffic against a slot-level reference model, and counter wrap.
module tb_mem_wb_pipeline_reg;

  typedef struct {
    logic [7:0]  top, bot, tm1Top, tm1Bot;
    logic [4:0]  rdTop, rdBot;
    logic        weTop, weBot, valid, tm1Valid, coll;
    logic [15:0] cnt;
  } outs_t;

  typedef struct {
    logic       stallV, flushV;
    logic [7:0] dTop, dBot;
    logic [4:0] rTop, rBot;
    logic       weT, weB, vIn;
    outs_t      exp;
  } vec_t;

  // One pipeline slot as the reference model sees it.
  typedef struct {
    logic [7:0] top, bot;
    logic [4:0] rdTop, rdBot;
    logic       weTop, weBot, valid, coll;
  } slot_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic stall = 1'b0, flush = 1'b0;
  logic [7:0] data_top_in = '0, data_bot_in = '0;
  logic [4:0] rd_top_in = '0, rd_bot_in = '0;
  logic we_top_in = 1'b0, we_bot_in = 1'b0, valid_in = 1'b0;
  logic [7:0] mem_wb_top, mem_wb_bot, mem_wb_tm1_top, mem_wb_tm1_bot;
  logic [4:0] rd_top, rd_bot;
  logic we_top, we_bot, valid, tm1_valid, wr_collision;
  logic [15:0] retire_count;

  int errors = 0;
  int checks = 0;

  slot_t modelCur, modelPrev;
  int    modelCount;

  vec_t vecs[16];

  mem_wb_pipeline_reg dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
    .data_top_in(data_top_in), .data_bot_in(data_bot_in),
    .rd_top_in(rd_top_in), .rd_bot_in(rd_bot_in),
    .we_top_in(we_top_in), .we_bot_in(we_bot_in), .valid_in(valid_in),
    .mem_wb_top(mem_wb_top), .mem_wb_bot(mem_wb_bot),
    .mem_wb_tm1_top(mem_wb_tm1_top), .mem_wb_tm1_bot(mem_wb_tm1_bot),
    .rd_top(rd_top), .rd_bot(rd_bot), .we_top(we_top), .we_bot(we_bot),
    .valid(valid), .tm1_valid(tm1_valid), .wr_collision(wr_collision),
    .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  function automatic outs_t expOut(logic [7:0] t, logic [7:0] b, logic [7:0] pt, logic [7:0] pb,
                                   logic [4:0] rt, logic [4:0] rb, logic wt, logic wb,
                                   logic v, logic pv, logic c, logic [15:0] n);
    outs_t o;
    o.top = t; o.bot = b; o.tm1Top = pt; o.tm1Bot = pb;
    o.rdTop = rt; o.rdBot = rb; o.weTop = wt; o.weBot = wb;
    o.valid = v; o.tm1Valid = pv; o.coll = c; o.cnt = n;
    return o;
  endfunction

  function automatic vec_t stim(logic s, logic f, logic [7:0] dt, logic [7:0] db,
                                logic [4:0] rt, logic [4:0] rb, logic wt, logic wb,
                                logic v, outs_t e);
    vec_t x;
    x.stallV = s; x.flushV = f; x.dTop = dt; x.dBot = db; x.rTop = rt; x.rBot = rb;
    x.weT = wt; x.weB = wb; x.vIn = v; x.exp = e;
    return x;
  endfunction

  // Reference model: a slot is what the instruction looks like once accepted.
  task automatic modelReset();
    modelCur   = '{default: '0};
    modelPrev  = '{default: '0};
    modelCount = 0;
  endtask

  task automatic modelAdvance();
    slot_t incoming;
    bit sameDest;
    if (stall && !flush) return;
    if (modelCur.valid) modelCount = (modelCount + 1) % 65536;
    modelPrev = modelCur;
    if (flush) begin
      modelCur = '{default: '0};
    end else begin
      sameDest = we_top_in && we_bot_in && (rd_top_in == rd_bot_in);
      incoming.top   = data_top_in;
      incoming.bot   = data_bot_in;
      incoming.rdTop = rd_top_in;
      incoming.rdBot = rd_bot_in;
      incoming.valid = valid_in;
      incoming.weTop = valid_in && we_top_in;
      incoming.weBot = valid_in && we_bot_in && !sameDest;
      incoming.coll  = valid_in && sameDest;
      modelCur = incoming;
    end
  endtask

  function automatic outs_t modelOuts();
    return expOut(modelCur.top, modelCur.bot, modelPrev.top, modelPrev.bot,
                  modelCur.rdTop, modelCur.rdBot, modelCur.weTop, modelCur.weBot,
                  modelCur.valid, modelPrev.valid, modelCur.coll, 16'(modelCount));
  endfunction

  task automatic applyStimulus(logic s, logic f, logic [7:0] dt, logic [7:0] db,
                               logic [4:0] rt, logic [4:0] rb, logic wt, logic wb, logic v);
    stall = s; flush = f; data_top_in = dt; data_bot_in = db;
    rd_top_in = rt; rd_bot_in = rb; we_top_in = wt; we_bot_in = wb; valid_in = v;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) modelAdvance();
    #1;
  endtask

  task automatic cmp(string tag, string field, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=0x%0h expected=0x%0h at %0t", tag, field, act, exp, $time);
    end
  endtask

  task automatic checkOutput(string tag, outs_t e);
    cmp(tag, "mem_wb_top", int'(mem_wb_top), int'(e.top));
    cmp(tag, "mem_wb_bot", int'(mem_wb_bot), int'(e.bot));
    cmp(tag, "tm1_top", int'(mem_wb_tm1_top), int'(e.tm1Top));
    cmp(tag, "tm1_bot", int'(mem_wb_tm1_bot), int'(e.tm1Bot));
    cmp(tag, "rd_top", int'(rd_top), int'(e.rdTop));
    cmp(tag, "rd_bot", int'(rd_bot), int'(e.rdBot));
    cmp(tag, "we_top", int'(we_top), int'(e.weTop));
    cmp(tag, "we_bot", int'(we_bot), int'(e.weBot));
    cmp(tag, "valid", int'(valid), int'(e.valid));
    cmp(tag, "tm1_valid", int'(tm1_valid), int'(e.tm1Valid));
    cmp(tag, "wr_collision", int'(wr_collision), int'(e.coll));
    cmp(tag, "retire_count", int'(retire_count), int'(e.cnt));
  endtask

  initial begin
    outs_t zero;
    int guard;
    zero = expOut(8'h00, 8'h00, 8'h00, 8'h00, 5'd0, 5'd0, 0, 0, 0, 0, 0, 16'h0000);

    // Directed table: streaming, stall, flush-during-stall, dual-write cases.
    vecs[0]  = stim(0,0,8'h11,8'h22,5'd1,5'd2,1,1,1, expOut(8'h11,8'h22,8'h00,8'h00,5'd1,5'd2,1,1,1,0,0,16'd0));
    vecs[1]  = stim(0,0,8'h33,8'h44,5'd3,5'd4,1,1,1, expOut(8'h33,8'h44,8'h11,8'h22,5'd3,5'd4,1,1,1,1,0,16'd1));
    vecs[2]  = stim(0,0,8'h55,8'h66,5'd5,5'd6,1,1,1, expOut(8'h55,8'h66,8'h33,8'h44,5'd5,5'd6,1,1,1,1,0,16'd2));
    vecs[3]  = stim(1,0,8'hAA,8'hBB,5'd7,5'd8,1,1,1, expOut(8'h55,8'h66,8'h33,8'h44,5'd5,5'd6,1,1,1,1,0,16'd2));
    vecs[4]  = stim(1,0,8'hAA,8'hBB,5'd7,5'd8,1,1,1, expOut(8'h55,8'h66,8'h33,8'h44,5'd5,5'd6,1,1,1,1,0,16'd2));
    vecs[5]  = stim(1,0,8'hAA,8'hBB,5'd7,5'd8,1,1,1, expOut(8'h55,8'h66,8'h33,8'h44,5'd5,5'd6,1,1,1,1,0,16'd2));
    vecs[6]  = stim(1,0,8'hAA,8'hBB,5'd7,5'd8,1,1,1, expOut(8'h55,8'h66,8'h33,8'h44,5'd5,5'd6,1,1,1,1,0,16'd2));
    vecs[7]  = stim(0,0,8'hAA,8'hBB,5'd7,5'd8,1,1,1, expOut(8'hAA,8'hBB,8'h55,8'h66,5'd7,5'd8,1,1,1,1,0,16'd3));
    vecs[8]  = stim(0,0,8'h77,8'h78,5'd9,5'd10,1,1,1, expOut(8'h77,8'h78,8'hAA,8'hBB,5'd9,5'd10,1,1,1,1,0,16'd4));
    vecs[9]  = stim(1,1,8'h99,8'h99,5'd3,5'd3,1,1,1, expOut(8'h00,8'h00,8'h77,8'h78,5'd0,5'd0,0,0,0,1,0,16'd5));
    vecs[10] = stim(0,0,8'h12,8'h34,5'd5,5'd5,1,1,1, expOut(8'h12,8'h34,8'h00,8'h00,5'd5,5'd5,1,0,1,0,1,16'd5));
    vecs[11] = stim(0,0,8'h56,8'h78,5'd5,5'd6,1,1,1, expOut(8'h56,8'h78,8'h12,8'h34,5'd5,5'd6,1,1,1,1,0,16'd6));
    vecs[12] = stim(0,0,8'h9A,8'hBC,5'd5,5'd5,1,1,0, expOut(8'h9A,8'hBC,8'h56,8'h78,5'd5,5'd5,0,0,0,1,0,16'd7));
    vecs[13] = stim(1,0,8'hEE,8'hFF,5'd1,5'd1,1,1,1, expOut(8'h9A,8'hBC,8'h56,8'h78,5'd5,5'd5,0,0,0,1,0,16'd7));
    vecs[14] = stim(0,0,8'h01,8'h02,5'd5,5'd5,1,0,1, expOut(8'h01,8'h02,8'h9A,8'hBC,5'd5,5'd5,1,0,1,0,0,16'd7));
    vecs[15] = stim(0,0,8'h03,8'h04,5'd4,5'd4,0,1,1, expOut(8'h03,8'h04,8'h01,8'h02,5'd4,5'd4,0,1,1,1,0,16'd8));

    modelReset();
    #2;
    checkOutput("reset_init", zero);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].stallV, vecs[i].flushV, vecs[i].dTop, vecs[i].dBot,
                    vecs[i].rTop, vecs[i].rBot, vecs[i].weT, vecs[i].weB, vecs[i].vIn);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset while stall and flush are both asserted.
    applyStimulus(1, 1, 8'hC3, 8'h3C, 5'd9, 5'd9, 1, 1, 1);
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset", zero);
    tick();
    checkOutput("reset_held", zero);
    #2;
    reset_n = 1'b1;
    applyStimulus(0, 0, 8'h5A, 8'hA5, 5'd3, 5'd4, 1, 1, 1);
    tick();
    checkOutput("reset_release", expOut(8'h5A,8'hA5,8'h00,8'h00,5'd3,5'd4,1,1,1,0,0,16'd0));

    // Randomized traffic with small address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                    8'($urandom), 8'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0));
      tick();
      checkOutput("rand", modelOuts());
    end

    // Drive the counter to its top value and across the wrap.
    applyStimulus(0, 0, 8'h10, 8'h20, 5'd1, 5'd2, 1, 1, 1);
    guard = 0;
    while ((modelCount != 65535) && (guard < 70000)) begin
      tick();
      guard++;
    end
    cmp("wrap", "reach_top", int'(guard < 70000), 1);
    cmp("wrap", "count_ffff", int'(retire_count), 16'hFFFF);
    checkOutput("wrap_top", modelOuts());
    tick();
    cmp("wrap", "count_0000", int'(retire_count), 16'h0000);
    checkOutput("wrap_zero", modelOuts());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
